mem_arbiter: RTL and testbench

Arbitrates a single-port unified memory between the instruction-fetch stage and the data (LW/SW) stage of the 16-bit CPU. It serialises requests, sequences each access through a fixed-latency memory, and returns read data with a one-cycle valid pulse. It also drives the pipeline `stall` line consumed by the decoder, which holds the PC while any request is outstanding.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_lat_cnt.sv | 34 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the unified-memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    function automatic int lat_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_cnt.sv
// rtl/mem_arbiter_lat_cnt.sv - loadable down-counter timing the memory read latency
module arb_lat_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises fetch and data accesses onto a single-port fixed-latency memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int               CNT_W = lat_cnt_w(MEM_LAT);
    localparam logic [CNT_W-1:0] LAT_V = CNT_W'(MEM_LAT);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              cnt_load, cnt_dec, cnt_last;

    arb_lat_cnt #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LAT_V),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                // Data first: it belongs to the older instruction in the pipe.
                if (d_req) begin
                    owner_d = OWN_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    state_d = ARB_ACCESS;
                end else if (if_req && !halt) begin
                    owner_d = OWN_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                cnt_load = 1'b1;
                state_d  = ARB_WAIT;
            end
            ARB_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    if (!we_q) begin
                        if (owner_q == OWN_D) d_rdata_d  = mem_rdata;
                        else                  if_rdata_d = mem_rdata;
                    end
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_en    = (state_q == ARB_ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = (state_q == ARB_DONE) && (owner_q == OWN_IF);
    assign d_valid   = (state_q == ARB_DONE) && (owner_q == OWN_D);
    assign stall     = (if_req && !if_valid) || (d_req && !d_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at MEM_LAT 1 and 3
module tb_mem_arbiter;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    exp_t        exp_if[$];
    exp_t        exp_d[$];
    exp_t        exp_if1[$];
    exp_t        mon_e;
    logic [15:0] mem [0:1023];

    logic        if_req, if_valid, d_req, d_we, d_valid, halt, mem_en, mem_we, stall;
    logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_req1, if_valid1, d_req1, d_we1, d_valid1, halt1, mem_en1, mem_we1, stall1;
    logic [15:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .halt(halt), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
        .if_valid(if_valid1), .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_valid(d_valid1), .halt(halt1), .mem_en(mem_en1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall(stall1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data is only meaningful exactly MEM_LAT cycles after mem_en.
    logic        p0v;
    logic [15:0] p0d;
    logic [2:0]  p1v;
    logic [15:0] p1d [3];
    always @(posedge clk) begin
        p0v    <= mem_en && !mem_we;
        p0d    <= mem[mem_addr[9:0]];
        p1v    <= {p1v[1:0], mem_en1 && !mem_we1};
        p1d[0] <= mem[mem_addr1[9:0]];
        p1d[1] <= p1d[0];
        p1d[2] <= p1d[1];
    end
    assign mem_rdata  = p0v    ? p0d    : 16'hDEAD;
    assign mem_rdata1 = p1v[2] ? p1d[2] : 16'hDEAD;

    always @(negedge clk) begin
        tests_run++;
        if (mem_we && !mem_en) begin
            tests_failed++;
            $display("FAIL mem_we_without_en cyc=%0d mem_we=%0b mem_en=%0b", cyc, mem_we, mem_en);
        end
        if (if_valid) begin
            tests_run++;
            if (exp_if.size() == 0) begin
                tests_failed++;
                $display("FAIL if_unexpected cyc=%0d if_rdata=%h", cyc, if_rdata);
            end else begin
                mon_e = exp_if.pop_front();
                if (if_rdata !== mon_e.data || cyc !== mon_e.cyc) begin
                    tests_failed++;
                    $display("FAIL if_valid got data=%h cyc=%0d exp data=%h cyc=%0d", if_rdata, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
        if (d_valid) begin
            tests_run++;
            if (exp_d.size() == 0) begin
                tests_failed++;
                $display("FAIL d_unexpected cyc=%0d d_rdata=%h", cyc, d_rdata);
            end else begin
                mon_e = exp_d.pop_front();
                if (d_rdata !== mon_e.data || cyc !== mon_e.cyc) begin
                    tests_failed++;
                    $display("FAIL d_valid got data=%h cyc=%0d exp data=%h cyc=%0d", d_rdata, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
        if (if_valid1) begin
            tests_run++;
            if (exp_if1.size() == 0) begin
                tests_failed++;
                $display("FAIL if3_unexpected cyc=%0d if_rdata=%h", cyc, if_rdata1);
            end else begin
                mon_e = exp_if1.pop_front();
                if (if_rdata1 !== mon_e.data || cyc !== mon_e.cyc) begin
                    tests_failed++;
                    $display("FAIL if3_valid got data=%h cyc=%0d exp data=%h cyc=%0d", if_rdata1, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({mem_en, mem_we, if_valid, d_valid, stall} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b exp=00000", {mem_en, mem_we, if_valid, d_valid, stall});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        tests_run++;
        if ({mem_en1, if_valid1, if_rdata1} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_lat3 got=%h exp=0", {mem_en1, if_valid1, if_rdata1});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        int c0;
        mem[10'h010] = 16'hA5C3;
        @(negedge clk);
        if_addr = 16'h0010;
        if_req  = 1'b1;
        c0 = cyc;
        exp_if.push_back('{16'hA5C3, c0 + 3});
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (mem_en !== (k == 1) || (k == 1 && mem_addr !== 16'h0010)) begin
                tests_failed++;
                $display("FAIL fetch_mem k=%0d got en=%0b addr=%h exp en=%0b addr=0010", k, mem_en, mem_addr, k == 1);
            end
            if (if_valid) if_req = 1'b0;
            #1;
            tests_run++;
            if (stall !== (k < 3)) begin
                tests_failed++;
                $display("FAIL fetch_stall k=%0d got=%0b exp=%0b", k, stall, k < 3);
            end
        end
    endtask

    task automatic test_contention();
        int c0;
        mem[10'h200] = 16'h1234;
        mem[10'h020] = 16'h5A5A;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        if_req = 1'b1; if_addr = 16'h0020;
        c0 = cyc;
        exp_d.push_back('{16'h1234, c0 + 3});
        exp_if.push_back('{16'h5A5A, c0 + 7});
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (mem_en !== (k == 1 || k == 5) ||
                (k == 1 && mem_addr !== 16'h0200) || (k == 5 && mem_addr !== 16'h0020)) begin
                tests_failed++;
                $display("FAIL contention_mem k=%0d got en=%0b addr=%h", k, mem_en, mem_addr);
            end
            if (d_valid)  d_req  = 1'b0;
            if (if_valid) if_req = 1'b0;
            #1;
            tests_run++;
            if (stall !== (k < 7)) begin
                tests_failed++;
                $display("FAIL contention_stall k=%0d got=%0b exp=%0b", k, stall, k < 7);
            end
        end
    endtask

    task automatic test_store();
        int c0;
        int wr_cnt = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        c0 = cyc;
        exp_d.push_back('{16'h1234, c0 + 3});
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (mem_en && mem_we) begin
                wr_cnt++;
                tests_run++;
                if (mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF || k != 1) begin
                    tests_failed++;
                    $display("FAIL store_write k=%0d got addr=%h wdata=%h exp k=1 addr=0040 wdata=beef", k, mem_addr, mem_wdata);
                end
            end
            if (d_valid) begin
                d_req = 1'b0;
                d_we  = 1'b0;
            end
        end
        tests_run++;
        if (wr_cnt != 1) begin
            tests_failed++;
            $display("FAIL store_count got=%0d exp=1", wr_cnt);
        end
    endtask

    task automatic test_halt();
        int c0;
        @(negedge clk);
        halt = 1'b1; if_req = 1'b1; if_addr = 16'h0010;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            tests_run++;
            if (mem_en !== 1'b0 || stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL halt_block k=%0d got en=%0b stall=%0b exp en=0 stall=1", k, mem_en, stall);
            end
        end
        @(negedge clk);
        halt = 1'b0; if_req = 1'b0;
        @(negedge clk);
        if_req = 1'b1;
        c0 = cyc;
        exp_if.push_back('{16'hA5C3, c0 + 3});
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (mem_en !== (k == 1)) begin
                tests_failed++;
                $display("FAIL halt_late_mem k=%0d got=%0b exp=%0b", k, mem_en, k == 1);
            end
            if (k == 2) halt = 1'b1;
            if (if_valid) if_req = 1'b0;
        end
        halt = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({mem_en, mem_we, if_valid, d_valid} !== 4'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ctrl got=%b exp=0000", {mem_en, mem_we, if_valid, d_valid});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin
            tests_failed++;
            $display("FAIL rstmid_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests_run++;
            if (d_valid !== 1'b0 || mem_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL rstmid_quiet k=%0d got valid=%0b en=%0b exp 0", k, d_valid, mem_en);
            end
        end
    endtask

    task automatic test_latency3();
        int c0;
        mem[10'h030] = 16'h3C3C;
        @(negedge clk);
        if_req1 = 1'b1; if_addr1 = 16'h0030;
        c0 = cyc;
        exp_if1.push_back('{16'h3C3C, c0 + 5});
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (mem_en1 !== (k == 1)) begin
                tests_failed++;
                $display("FAIL lat3_mem k=%0d got=%0b exp=%0b", k, mem_en1, k == 1);
            end
            if (if_valid1) if_req1 = 1'b0;
            #1;
            tests_run++;
            if (stall1 !== (k < 5)) begin
                tests_failed++;
                $display("FAIL lat3_stall k=%0d got=%0b exp=%0b", k, stall1, k < 5);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        {if_req, d_req, d_we, halt} = '0;
        {if_addr, d_addr, d_wdata} = '0;
        {if_req1, d_req1, d_we1, halt1} = '0;
        {if_addr1, d_addr1, d_wdata1} = '0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_halt();
        test_reset_mid();
        test_latency3();
        repeat (2) @(negedge clk);
        tests_run++;
        if (exp_if.size() + exp_d.size() + exp_if1.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_if.size() + exp_d.size() + exp_if1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
